sa_result_collector: RTL
========================

Name: sa_result_collector

Overview:
- Return path of the systolic array: drains finished PE accumulators row by row after a tile multiply completes.
- Converts each ACC_W accumulator to D_W fixed point.
- Stages one SA_R x SA_C tile, then commits it atomically into an OUT_R x OUT_C output matrix at the given tile coordinates.
- Signals full-matrix completion to the attention datapath through O_DATA_VLD and O_MATRIX.

Parameters:
D_W, 16, output element width (signed fixed point)
ACC_W, 32, PE accumulator width on I_ROW_DATA
FRAC_W, 8, arithmetic right shift applied before narrowing
SA_R, 16, systolic array rows (rows per tile)
SA_C, 16, systolic array columns (elements per row vector)
OUT_R, 64, output matrix rows (multiple of SA_R)
OUT_C, 64, output matrix columns (multiple of SA_C)

Ports:
I_CLK  in  1  clock
I_SYNC_RST  in  1  synchronous active-high reset
I_START  in  1  pulse: begin a new output matrix; clears matrix, bitmap, flags
I_DRAIN_START  in  1  pulse: SA tile finished, begin drain
I_TILE_R  in  $clog2(OUT_R/SA_R)+1  tile row index, sampled with I_DRAIN_START
I_TILE_C  in  $clog2(OUT_C/SA_C)+1  tile column index, sampled with I_DRAIN_START
O_DRAIN_SHIFT  out  1  one-cycle request to SA: shift one accumulator row out
I_ROW_VLD  in  1  row vector valid
I_ROW_DATA  in  SA_C*ACC_W  row vector; element j at bits [j*ACC_W +: ACC_W]
O_BUSY  out  1  high in any state other than IDLE
O_TILE_DONE  out  1  pulse: tile drained and committed or discarded
O_TILE_ERR  out  1  pulse with O_TILE_DONE: tile index out of range, commit suppressed
O_DATA_VLD  out  1  level: every tile of the matrix committed at least once
O_MATRIX  out  OUT_R*OUT_C*D_W  output matrix; element (r,c) at bits [(r*OUT_C+c)*D_W +: D_W]

Behaviour:
- Reset: all outputs 0; state IDLE; tile buffer, O_MATRIX, tile bitmap and committed-tile counter cleared.
- States: IDLE, REQ, WAIT, COMMIT, DONE.
- IDLE:
  - I_DRAIN_START=1 -> latch tile indices, row_cnt=0, go to REQ.
  - I_DRAIN_START is ignored while O_BUSY=1.
- REQ:
  - O_DRAIN_SHIFT=1 for exactly this cycle, then WAIT.
  - Request-to-row latency is at least 1 cycle; only one request is ever outstanding.
- WAIT:
  - On I_ROW_VLD=1, write the converted row into buffer row SA_R-1-row_cnt; the bottom PE row shifts out first.
  - row_cnt++. If row_cnt reaches SA_R, go to COMMIT; otherwise go to REQ.
- I_ROW_VLD outside WAIT: ignored, no state change.
- COMMIT (1 cycle):
  - If tile_r < OUT_R/SA_R and tile_c < OUT_C/SA_C: copy buffer into O_MATRIX rows tile_r*SA_R.., cols tile_c*SA_C...
  - If the tile bitmap bit is clear, set it and increment the counter.
  - A re-committed tile overwrites its data; the count does not change.
  - Indices out of range: no write; set the error flag. Go to DONE.
- DONE (1 cycle):
  - O_TILE_DONE=1; O_TILE_ERR=flag.
  - O_DATA_VLD set this cycle if counter == (OUT_R/SA_R)*(OUT_C/SA_C).
  - Go to IDLE.
- O_DATA_VLD holds until I_START or reset.
- Minimum tile time: 2*SA_R + 2 cycles, with 1-cycle row latency.
- Conversion per element: arithmetic shift right of the signed ACC_W value by FRAC_W, then narrowing to D_W. Narrowing rule is set by the optional feature.
- I_START in any state:
  - Abort; go to IDLE next cycle.
  - Clear O_MATRIX, bitmap, counter, O_DATA_VLD; no O_TILE_DONE.
  - If I_START and I_DRAIN_START are high together, I_START wins and the drain is not started.
- I_SYNC_RST mid-drain: identical to reset. The SA side is reset by the same signal.

Optional Feature:
- Macro: SA_COLLECT_SAT_EN.
- Defined: narrowing saturates to the signed D_W range, [-2^(D_W-1), 2^(D_W-1)-1].
- Undefined: narrowing keeps the low D_W bits (two's-complement wrap).

Test Plan:
1. Reset, I_DRAIN_START tile (0,0); SA model answers each O_DRAIN_SHIFT one cycle later with row k = ACC values (k<<8) -> exactly 16 O_DRAIN_SHIFT pulses; O_MATRIX row 15-k of tile (0,0) = k; O_TILE_DONE at cycle 34 after start; O_DATA_VLD=0.
2. Commit all 16 tiles, tile (3,3) last -> O_DATA_VLD rises with the 16th O_TILE_DONE; re-drain tile (1,2) with new data -> data overwritten, O_DATA_VLD stays 1.
3. Conversion: element 0x0001_0000 -> 0x0100 both builds. 0x0100_0000 -> 0x0000 wrap / 0x7FFF sat. 0xFF00_0000 -> 0x0000 wrap / 0x8000 sat.
4. Tile index (4,0) -> full 16-row drain still performed; O_TILE_DONE and O_TILE_ERR pulse together; O_MATRIX unchanged; counter unchanged.
5. I_START asserted after 5 rows drained -> IDLE next cycle, O_BUSY=0, O_MATRIX all zero, no O_TILE_DONE; a new I_DRAIN_START is accepted afterwards.
6. Spurious I_ROW_VLD in IDLE and in REQ, plus I_DRAIN_START while busy -> ignored; row placement and count for the in-flight tile unaffected.

Source files
------------

// File: rtl/sa_result_collector.sv
// Systolic-array result collector: drains SA_R accumulator rows per tile, narrows each to D_W and commits the tile into O_MATRIX.
// One tile takes 2*SA_R+2 cycles at 1-cycle row latency, with one shift outstanding; define SA_COLLECT_SAT_EN for saturating narrowing (default wraps).
module sa_result_collector #(
  parameter int D_W    = 16,
  parameter int ACC_W  = 32,
  parameter int FRAC_W = 8,
  parameter int SA_R   = 16,
  parameter int SA_C   = 16,
  parameter int OUT_R  = 64,
  parameter int OUT_C  = 64
) (
  input  logic                          I_CLK,
  input  logic                          I_SYNC_RST,
  input  logic                          I_START,
  input  logic                          I_DRAIN_START,
  input  logic [$clog2(OUT_R/SA_R):0]   I_TILE_R,
  input  logic [$clog2(OUT_C/SA_C):0]   I_TILE_C,
  output logic                          O_DRAIN_SHIFT,
  input  logic                          I_ROW_VLD,
  input  logic [SA_C*ACC_W-1:0]         I_ROW_DATA,
  output logic                          O_BUSY,
  output logic                          O_TILE_DONE,
  output logic                          O_TILE_ERR,
  output logic                          O_DATA_VLD,
  output logic [OUT_R*OUT_C*D_W-1:0]    O_MATRIX
);

  localparam int TILES_R = OUT_R / SA_R;
  localparam int TILES_C = OUT_C / SA_C;
  localparam int N_TILES = TILES_R * TILES_C;
  localparam int TR_W    = $clog2(TILES_R) + 1;
  localparam int TC_W    = $clog2(TILES_C) + 1;
  localparam int RC_W    = $clog2(SA_R + 1);
  localparam int CNT_W   = $clog2(N_TILES + 1);
  localparam int ROW_W   = SA_C * D_W;

`ifdef SA_COLLECT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_COMMIT,
    ST_DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [TR_W-1:0]         tile_r;
  logic [TC_W-1:0]         tile_c;
  logic [RC_W-1:0]         row_cnt;
  logic [SA_R*ROW_W-1:0]   tile_buf;
  logic [N_TILES-1:0]      bitmap;
  logic [CNT_W-1:0]        tile_cnt;
  logic                    err_flag;
  logic                    data_vld_q;
  logic                    in_range;
  logic [ROW_W-1:0]        conv_row;

  function automatic logic [D_W-1:0] narrow(input logic [ACC_W-1:0] acc);
`ifdef SA_COLLECT_SAT_EN
    logic signed [ACC_W-1:0] sh;
    logic [D_W-1:0]          res;
    sh = $signed(acc) >>> FRAC_W;
    if (sh > SAT_MAX)
      res = SAT_MAX[D_W-1:0];
    else if (sh < SAT_MIN)
      res = SAT_MIN[D_W-1:0];
    else
      res = sh[D_W-1:0];
    return res;
`else
    return D_W'($signed(acc) >>> FRAC_W);
`endif
  endfunction

  always_comb begin
    conv_row = '0;
    for (int j = 0; j < SA_C; j++)
      conv_row[j*D_W +: D_W] = narrow(I_ROW_DATA[j*ACC_W +: ACC_W]);
  end

  assign in_range = (tile_r < TR_W'(TILES_R)) && (tile_c < TC_W'(TILES_C));

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    O_DRAIN_SHIFT = 1'b0;
    O_TILE_DONE   = 1'b0;
    O_TILE_ERR    = 1'b0;
    O_BUSY        = (state != ST_IDLE);
    O_DATA_VLD    = data_vld_q;
    case (state)
      ST_IDLE: begin
        if (I_DRAIN_START)
          state_nxt = ST_REQ;
      end
      ST_REQ: begin
        O_DRAIN_SHIFT = 1'b1;
        state_nxt     = ST_WAIT;
      end
      ST_WAIT: begin
        if (I_ROW_VLD)
          state_nxt = (row_cnt == RC_W'(SA_R - 1)) ? ST_COMMIT : ST_REQ;
      end
      ST_COMMIT: begin
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        O_TILE_DONE = 1'b1;
        O_TILE_ERR  = err_flag;
        // The counter was updated by COMMIT, so completion is visible with this pulse.
        if (tile_cnt == CNT_W'(N_TILES))
          O_DATA_VLD = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (I_START)
      state_nxt = ST_IDLE;
  end

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      tile_r     <= '0;
      tile_c     <= '0;
      row_cnt    <= '0;
      tile_buf   <= '0;
      bitmap     <= '0;
      tile_cnt   <= '0;
      err_flag   <= 1'b0;
      data_vld_q <= 1'b0;
      O_MATRIX   <= '0;
    end else if (I_START) begin
      bitmap     <= '0;
      tile_cnt   <= '0;
      err_flag   <= 1'b0;
      data_vld_q <= 1'b0;
      O_MATRIX   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (I_DRAIN_START) begin
            tile_r  <= I_TILE_R;
            tile_c  <= I_TILE_C;
            row_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (I_ROW_VLD) begin
            // Bottom PE row arrives first, so fill the buffer from the last row upward.
            for (int r = 0; r < SA_R; r++)
              if (row_cnt == RC_W'(SA_R - 1 - r))
                tile_buf[r*ROW_W +: ROW_W] <= conv_row;
            row_cnt <= row_cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          err_flag <= !in_range;
          for (int tr = 0; tr < TILES_R; tr++) begin
            for (int tc = 0; tc < TILES_C; tc++) begin
              if (tile_r == TR_W'(tr) && tile_c == TC_W'(tc)) begin
                for (int r = 0; r < SA_R; r++)
                  O_MATRIX[((tr*SA_R + r)*OUT_C + tc*SA_C)*D_W +: ROW_W] <= tile_buf[r*ROW_W +: ROW_W];
                if (!bitmap[tr*TILES_C + tc]) begin
                  bitmap[tr*TILES_C + tc] <= 1'b1;
                  tile_cnt                <= tile_cnt + 1'b1;
                end
              end
            end
          end
        end
        ST_DONE: begin
          if (tile_cnt == CNT_W'(N_TILES))
            data_vld_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
